// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - halt / single-step / free-run sequencer producing a CPU clock enable
//
// Ports:
//   clk          board clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   btn_run      raw button, a press toggles between run and halt
//   btn_step     raw button, a press issues one step while halted
//   speed_sel    run rate: 00 every cycle, 01 every 256, 10 every 65536, 11 every 2^24 cycles
//   bp_en        breakpoint enable
//   bp_addr      breakpoint address
//   pc           current CPU program counter
//   cpu_ce       CPU clock enable, one cycle per instruction
//   running      high while in RUN
//   halted_at_bp high while halted because of a breakpoint
//   step_count   number of cpu_ce pulses issued since reset (wraps)
module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PC_WIDTH        = 8,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_run,
  input  logic                   btn_step,
  input  logic [1:0]             speed_sel,
  input  logic                   bp_en,
  input  logic [PC_WIDTH-1:0]    bp_addr,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   cpu_ce,
  output logic                   running,
  output logic                   halted_at_bp,
  output logic [COUNT_WIDTH-1:0] step_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_HALT, S_STEP, S_RUN} state_t;

  state_t      state, state_next;
  logic [1:0]  btn_raw;
  logic [1:0]  press;          // [0] run, [1] step
  logic        run_press, step_press;
  logic [23:0] prescaler;
  logic [23:0] period_m1;
  logic        tick;
  logic        skip_bp;
  logic        bp_hit;
  logic        bp_stop;

  assign btn_raw    = {btn_step, btn_run};
  assign run_press  = press[0];
  assign step_press = press[1];

  // Per-button synchronizer, debouncer and rising-edge detector. The press
  // pulse is taken from the registered accepted level so it is glitch free.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync1, sync2;
    logic            acc, acc_q, press_r;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        acc     <= 1'b0;
        acc_q   <= 1'b0;
        press_r <= 1'b0;
        db_cnt  <= '0;
      end else begin
        sync1   <= btn_raw[i];
        sync2   <= sync1;
        acc_q   <= acc;
        press_r <= acc & ~acc_q;
        if (sync2 == acc) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
          acc    <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    assign press[i] = press_r;
  end

  always_comb begin
    case (speed_sel)
      2'b00:   period_m1 = 24'h00_0000;
      2'b01:   period_m1 = 24'h00_00FF;
      2'b10:   period_m1 = 24'h00_FFFF;
      default: period_m1 = 24'hFF_FFFF;
    endcase
  end

  // >= so that lowering the period mid-run fires at once instead of wrapping.
  assign tick    = (prescaler >= period_m1);
  assign bp_hit  = bp_en & (pc == bp_addr) & ~skip_bp;
  assign bp_stop = (state == S_RUN) & ~run_press & tick & bp_hit;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_HALT;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_HALT: begin
        if (run_press)       state_next = S_RUN;   // run wins over a simultaneous step
        else if (step_press) state_next = S_STEP;
      end
      S_STEP: state_next = S_HALT;
      S_RUN: begin
        if (run_press || bp_stop) state_next = S_HALT;
      end
      default: state_next = S_HALT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running = (state == S_RUN);
    cpu_ce  = (state == S_STEP) |
              ((state == S_RUN) & tick & ~bp_hit & ~run_press);
  end

  // Prescaler, breakpoint bookkeeping and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= '0;
      skip_bp      <= 1'b0;
      halted_at_bp <= 1'b0;
      step_count   <= '0;
    end else begin
      // Counts only while staying in RUN, so it is zero on entry and in HALT.
      if (state == S_RUN && state_next == S_RUN)
        prescaler <= tick ? 24'd0 : prescaler + 24'd1;
      else
        prescaler <= 24'd0;

      // Resuming from a breakpoint address must execute that instruction once.
      if (state == S_HALT && state_next == S_RUN)
        skip_bp <= 1'b1;
      else if (state == S_RUN && cpu_ce)
        skip_bp <= 1'b0;

      if (bp_stop)
        halted_at_bp <= 1'b1;
      else if (state == S_HALT && state_next != S_HALT)
        halted_at_bp <= 1'b0;

      if (cpu_ce)
        step_count <= step_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench for cpu_run_controller
module tb_cpu_run_controller;

  localparam int PW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_run, btn_step;
  logic [1:0]    speed_sel;
  logic          bp_en;
  logic [PW-1:0] bp_addr;
  logic [PW-1:0] pc;
  logic          cpu_ce, running, halted_at_bp;
  logic [CW-1:0] step_count;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES(4),
    .PC_WIDTH(PW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .speed_sel(speed_sel), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .running(running), .halted_at_bp(halted_at_bp),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU model: pc advances once per enabled cycle
  always @(posedge clk) begin
    if (rst)         pc <= '0;
    else if (cpu_ce) pc <= pc + 1'b1;
  end

  typedef struct {
    int            at;
    logic [PW-1:0] pc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            passes = 0;
  logic [PW-1:0] exp_pc;
  logic [CW-1:0] exp_cnt;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, expv);
  endtask

  task automatic push_ce(input int at);
    exp_t e;
    e.at  = at;
    e.pc  = exp_pc;
    e.cnt = exp_cnt;
    q.push_back(e);
    exp_pc  = exp_pc + 1'b1;
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pc  = '0;
    exp_cnt = '0;
  endtask

  // Monitor: every cpu_ce pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0 && cpu_ce) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_ce: cpu_ce=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q.pop_front();
        if (cyc == e.at && pc == e.pc && step_count == e.cnt)
          passes++;
        else
          $display("FAIL ce_pulse: cycle/pc/count %0d/%0d/%0d, required %0d/%0d/%0d",
                   cyc, pc, step_count, e.at, e.pc, e.cnt);
      end
    end
  end

  initial begin
    int t, s, z, n;
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0;
    speed_sel = 2'b00; bp_en = 1'b0; bp_addr = '0;
    exp_pc = '0; exp_cnt = '0;
    goto(3);
    rst = 1'b0;
    check("rst_cpu_ce", cpu_ce, 0);
    check("rst_running", running, 0);
    check("rst_halted_at_bp", halted_at_bp, 0);
    check("rst_step_count", step_count, 0);

    // Held step button: one pulse, 8 cycles after the edge
    t = cyc + 2; goto(t);
    push_ce(t + 8);
    btn_step = 1'b1; goto(t + 12); btn_step = 1'b0;
    goto(t + 30);
    check("step_count_1", step_count, 1);
    check("step_pc_1", pc, 1);
    check("step_pending", q.size(), 0);

    // Bouncing buttons never get accepted
    t = cyc;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_step = ~btn_step;
      goto(t + i + 1);
    end
    btn_step = 1'b0; goto(cyc + 20);
    check("bounce_step_count", step_count, 1);
    t = cyc;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_run = ~btn_run;
      goto(t + i + 1);
      if (running) check("bounce_running", running, 0);
    end
    btn_run = 1'b0; goto(cyc + 20);
    check("bounce_run_running", running, 0);

    // Free run at speed 00, then 01; step ignored while running
    speed_sel = 2'b00;
    t = cyc;
    for (int k = 0; k < 10; k++) push_ce(t + 8 + k);
    s = t + 18;
    push_ce(s + 255);
    push_ce(s + 511);
    btn_run = 1'b1; goto(t + 12); btn_run = 1'b0;
    check("run_running", running, 1);
    goto(s); speed_sel = 2'b01;
    goto(s + 20); btn_step = 1'b1; goto(s + 32); btn_step = 1'b0;
    goto(s + 100);
    check("run01_running", running, 1);
    goto(s + 520); btn_run = 1'b1; goto(s + 532); btn_run = 1'b0;
    goto(s + 800);
    check("stop_running", running, 0);
    check("speed_pending", q.size(), 0);

    // Breakpoint at 5 from pc=0
    speed_sel = 2'b00;
    pulse_rst();
    bp_en = 1'b1; bp_addr = 8'h05;
    t = cyc + 1; goto(t);
    for (int k = 0; k < 5; k++) push_ce(t + 8 + k);
    btn_run = 1'b1; goto(t + 12); btn_run = 1'b0;
    goto(t + 25);
    check("bp_running", running, 0);
    check("bp_halted", halted_at_bp, 1);
    check("bp_pc", pc, 5);
    check("bp_count", step_count, 5);
    check("bp_pending", q.size(), 0);

    // Step ignores the breakpoint and clears halted_at_bp
    t = cyc; push_ce(t + 8);
    btn_step = 1'b1; goto(t + 12); btn_step = 1'b0;
    goto(t + 25);
    check("bp_step_halted", halted_at_bp, 0);
    check("bp_step_pc", pc, 6);

    // Halt at 8, then resume executes pc=8 despite the match
    bp_addr = 8'h08;
    t = cyc; push_ce(t + 8); push_ce(t + 9);
    btn_run = 1'b1; goto(t + 12); btn_run = 1'b0;
    goto(t + 25);
    check("bp8_halted", halted_at_bp, 1);
    check("bp8_pc", pc, 8);
    t = cyc; z = t + 30;
    for (int k = 0; k < 29; k++) push_ce(t + 8 + k);
    btn_run = 1'b1; goto(t + 12); btn_run = 1'b0;
    goto(t + 20);
    check("resume_running", running, 1);
    check("resume_halted", halted_at_bp, 0);
    goto(z); btn_run = 1'b1; goto(z + 12); btn_run = 1'b0;
    goto(z + 25);
    check("resume_stop_running", running, 0);
    check("resume_pc", pc, 37);
    check("resume_pending", q.size(), 0);

    // Run up to step_count=0xFFFF, then one step wraps it
    bp_en = 1'b0;
    n = 65535 - int'(exp_cnt);
    t = cyc;
    for (int k = 0; k < n; k++) push_ce(t + 8 + k);
    btn_run = 1'b1; goto(t + 12); btn_run = 1'b0;
    goto(t + 1 + n); btn_run = 1'b1; goto(t + 13 + n); btn_run = 1'b0;
    goto(t + n + 30);
    check("pre_wrap_count", step_count, 65535);
    check("pre_wrap_running", running, 0);
    t = cyc; push_ce(t + 8);
    btn_step = 1'b1; goto(t + 12); btn_step = 1'b0;
    goto(t + 25);
    check("wrap_count", step_count, 0);

    // Simultaneous presses: RUN wins; then reset mid-run
    t = cyc;
    for (int k = 0; k < 10; k++) push_ce(t + 8 + k);
    btn_run = 1'b1; btn_step = 1'b1;
    goto(t + 8);
    check("both_running_a", running, 1);
    goto(t + 9);
    check("both_running_b", running, 1);
    goto(t + 12); btn_run = 1'b0; btn_step = 1'b0;
    goto(t + 17); rst = 1'b1;
    goto(t + 18);
    check("midrst_cpu_ce", cpu_ce, 0);
    check("midrst_running", running, 0);
    check("midrst_count", step_count, 0);
    goto(t + 19); rst = 1'b0;
    goto(cyc + 10);
    check("final_pending", q.size(), 0);
    check("final_cpu_ce", cpu_ce, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
